// File: rtl/imem_loader.sv
// Byte-serial program loader: parses a framed image, writes 28-bit words into the
// instruction RAM and holds the CPU in reset until a frame with a good checksum arrives.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned DEPTH      = 256,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic                  oCPUReset,
    output logic                  oDone,
    output logic                  oError
);

    // Holds the first three bytes of a word; the upper nibble of byte 0 falls off the top.
    localparam int unsigned AsmWidth = DATA_WIDTH - 8;

    typedef enum logic [2:0] {
        StSync,
        StCntHi,
        StCntLo,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [AsmWidth-1:0]   asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_rst_q, cpu_rst_d;

    logic                  accept;
    logic [15:0]           cnt_full;
    logic                  last_word;

    assign accept    = iByteValid && ready_q;
    assign cnt_full  = {cnt_q[15:8], iByte};
    assign last_word = (32'(word_q) + 32'd1) == 32'(cnt_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            StSync: begin
                if (accept && iByte == SYNC_BYTE) begin
                    state_d = StCntHi;
                    csum_d  = 8'h00;
                    word_d  = '0;
                    idx_d   = 2'd0;
                end
            end
            StCntHi: begin
                if (accept) begin
                    cnt_d[15:8] = iByte;
                    csum_d      = csum_q ^ iByte;
                    state_d     = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    cnt_d  = cnt_full;
                    csum_d = csum_q ^ iByte;
                    idx_d  = 2'd0;
                    if (32'(cnt_full) > DEPTH) begin
                        state_d = StError;
                    end else if (cnt_full == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ iByte;
                    asm_d  = {asm_q[AsmWidth-9:0], iByte};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {asm_q, iByte};
                        waddr_d = word_q;
                        word_d  = word_q + 1'b1;
                        if (last_word) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (iByte == csum_q) ? StDone : StError;
                end
            end
            StDone, StError: begin
                if (iStart) begin
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        ready_d   = (state_d != StDone) && (state_d != StError);
        done_d    = (state_d == StDone);
        error_d   = (state_d == StError);
        cpu_rst_d = (state_d != StDone);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= StSync;
            idx_q     <= 2'd0;
            cnt_q     <= 16'd0;
            word_q    <= '0;
            csum_q    <= 8'h00;
            asm_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            csum_q    <= csum_d;
            asm_q     <= asm_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign oByteReady    = ready_q;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = waddr_q;
    assign oWriteData    = wdata_q;
    assign oCPUReset     = cpu_rst_q;
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives framed images, scoreboards every RAM write
// (address, data, cycle) and checks the status outputs after each frame.
module tb_imem_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oWriteData;
    logic        oCPUReset;
    logic        oDone;
    logic        oError;

    imem_loader #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(28),
        .DEPTH     (256),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oWriteEnable (oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oWriteData   (oWriteData),
        .oCPUReset    (oCPUReset),
        .oDone        (oDone),
        .oError       (oError)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] addr;
        logic [27:0] data;
        int          at;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          stalls = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A write must appear in the cycle right after its 4th byte is accepted.
    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {16'h0, oWriteAddress}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("waddr", {16'h0, oWriteAddress}, {16'h0, mon_e.addr});
                check("wdata", {4'h0, oWriteData}, {4'h0, mon_e.data});
                check("wcycle", cyc - 1, mon_e.at);
            end
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input bit wr = 1'b0,
                             input logic [15:0] wa = 16'h0, input logic [27:0] wd = 28'h0);
        int   n;
        wr_t  e;
        n = 0;
        iByte      = b;
        iByteValid = 1'b1;
        while (oByteReady !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        stalls += n;
        if (oByteReady !== 1'b1) check("ready_timeout", {31'h0, oByteReady}, 32'h1);
        @(posedge Clock);
        if (wr) begin
            e.addr = wa;
            e.data = wd;
            e.at   = cyc;
            sb.push_back(e);
        end
        @(negedge Clock);
        iByteValid = 1'b0;
    endtask

    task automatic send_frame(input bit use_ovr, input logic [7:0] ovr);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        logic [7:0]  b;
        n  = 16'(words.size());
        cs = n[15:8] ^ n[7:0];
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                b  = w[31 - 8 * k -: 8];
                cs = cs ^ b;
                send_byte(b, k == 3, 16'(i), w[27:0]);
            end
        end
        send_byte(use_ovr ? ovr : cs);
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        iByte      = 8'hA5;
        iByteValid = 1'b1;
        @(negedge Clock);
        iStart     = 1'b0;
        iByteValid = 1'b0;
        check("start_ready", {31'h0, oByteReady}, 32'h1);
        check("start_done", {31'h0, oDone}, 32'h0);
        check("start_error", {31'h0, oError}, 32'h0);
        check("start_cpurst", {31'h0, oCPUReset}, 32'h1);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        check({tag, "_done"}, {31'h0, oDone}, {31'h0, done});
        check({tag, "_error"}, {31'h0, oError}, {31'h0, err});
        check({tag, "_cpurst"}, {31'h0, oCPUReset}, {31'h0, !done});
        check({tag, "_ready"}, {31'h0, oByteReady}, 32'h0);
        check({tag, "_pending"}, sb.size(), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, oByteReady}, 32'h0);
        check({tag, "_we"}, {31'h0, oWriteEnable}, 32'h0);
        check({tag, "_waddr"}, {16'h0, oWriteAddress}, 32'h0);
        check({tag, "_wdata"}, {4'h0, oWriteData}, 32'h0);
        check({tag, "_cpurst"}, {31'h0, oCPUReset}, 32'h1);
        check({tag, "_done"}, {31'h0, oDone}, 32'h0);
        check({tag, "_error"}, {31'h0, oError}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        Reset      = 1'b0;
        iStart     = 1'b0;
        iByte      = 8'h00;
        iByteValid = 1'b0;

        // Reset sequencing
        repeat (3) @(negedge Clock);
        check_reset_outputs("rst");
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_release_ready", {31'h0, oByteReady}, 32'h1);
        check("rst_release_cpurst", {31'h0, oCPUReset}, 32'h1);

        // Single-word frame, checksum 7B
        words = '{32'h0A12_3456};
        send_frame(1'b0, 8'h00);
        check_status("single", 1'b1, 1'b0);

        // Back-to-back 3-word frame; the A5 shown during iStart must be ignored
        pulse_start();
        words  = '{32'h0123_4567, 32'hFFFF_FFFF, 32'h089A_BCDE};
        stalls = 0;
        send_frame(1'b0, 8'h00);
        check("b2b_stalls", stalls, 32'h0);
        check_status("b2b", 1'b1, 1'b0);

        // Bad checksum
        pulse_start();
        words = '{32'h0A12_3456};
        send_frame(1'b1, 8'h7C);
        check_status("badcs", 1'b0, 1'b1);
        repeat (2) @(negedge Clock);
        check("badcs_hold_error", {31'h0, oError}, 32'h1);

        // Garbage before sync, then N == 0
        pulse_start();
        send_byte(8'h00);
        send_byte(8'hFF);
        words = {};
        send_frame(1'b0, 8'h00);
        check_status("zero", 1'b1, 1'b0);

        // Oversize count
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check_status("oversize", 1'b0, 1'b1);
        repeat (3) @(negedge Clock);
        check("oversize_ready_held", {31'h0, oByteReady}, 32'h0);

        // Reset mid-DATA aborts the frame without writes
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_outputs("midrst");
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_ready", {31'h0, oByteReady}, 32'h1);
        repeat (4) @(negedge Clock);
        words = '{32'h0BEE_F123};
        send_frame(1'b0, 8'h00);
        check_status("after_rst", 1'b1, 1'b0);

        repeat (2) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction ROM. Receives a byte-serial program image over a valid/ready stream and writes 28-bit instruction words into a writable instruction memory, starting at address 0.
- Holds the CPU in reset while loading. Releases it only after a frame with a correct checksum.
- Sits between the host/UART byte stream and the instruction RAM write port. The CPU fetch path is unchanged.

Parameters:
- ADDR_WIDTH, 16, width of the instruction address.
- DATA_WIDTH, 28, instruction width. Each word occupies 4 bytes on the wire; the upper 4 bits of byte 0 are ignored.
- DEPTH, 256, number of writable instruction locations.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- iStart  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- iByte  in  8  stream data.
- iByteValid  in  1  iByte is valid this cycle.
- oByteReady  out  1  loader accepts a byte this cycle.
- oWriteEnable  out  1  one-cycle instruction-memory write strobe.
- oWriteAddress  out  ADDR_WIDTH  write address.
- oWriteData  out  DATA_WIDTH  instruction word.
- oCPUReset  out  1  active-high hold-in-reset to the CPU.
- oDone  out  1  load completed, checksum good.
- oError  out  1  load aborted.

Behaviour:
- Reset (Reset==0 at a clock edge) sets every output to a fixed value:
  - oByteReady=0, oWriteEnable=0, oWriteAddress=0, oWriteData=0, oCPUReset=1, oDone=0, oError=0.
  - State=SYNC; byte index=0; word count=0; checksum=0.
  - Reset wins over every other input in the same cycle, and aborts a load mid-frame.
- A byte is accepted on a cycle where iByteValid && oByteReady. oByteReady=1 in SYNC, CNT_HI, CNT_LO, DATA and CHECK; it is 0 in DONE and ERROR.
- Frame format: SYNC_BYTE, N[15:8], N[7:0], then N×4 data bytes (each word most-significant byte first), then a checksum byte. The checksum is the XOR of the two count bytes and all data bytes.
- SYNC: an accepted byte equal to SYNC_BYTE moves to CNT_HI and clears checksum and address. Any other byte is discarded and the state stays SYNC.
- CNT_HI: an accepted byte moves to CNT_LO.
- CNT_LO: an accepted byte completes N and leads to one of three states:
  - N > DEPTH goes to ERROR.
  - N == 0 goes to CHECK.
  - Otherwise the state goes to DATA.
- DATA: the byte index counts 0..3 and bytes shift into a 32-bit assembly register.
  - On acceptance of byte 3, the next cycle has oWriteEnable=1, oWriteData = assembled[27:0], and oWriteAddress = current word index.
  - The address increments after the write.
  - oByteReady stays 1 during the write cycle; back-to-back bytes never stall.
  - After the write of word N-1, the state goes to CHECK.
- CHECK: an accepted byte equal to the running checksum goes to DONE. Otherwise the state goes to ERROR.
- DONE: oDone=1 and oCPUReset=0, registered one cycle after the checksum byte is accepted.
- ERROR: oError=1 and oCPUReset=1. Words already written remain in memory.
- DONE or ERROR with iStart=1: go to SYNC; oCPUReset=1; oDone=0; oError=0.
  - iStart is ignored in every other state.
  - A byte presented in the iStart cycle is not accepted.
- oWriteAddress wraps at DEPTH only by construction; N ≤ DEPTH guarantees no overflow.
- The checksum includes the count bytes and excludes the sync byte.

Test Plan:
- Reset sequencing: hold Reset=0 for 3 cycles, then release. Outputs take their reset values and oByteReady=1 one cycle after release. Assert Reset=0 mid-DATA: no further writes occur and the state returns to SYNC.
- Single-word frame: send A5 00 01 0A 12 34 56, checksum 00^01^0A^12^34^56=0x7B. Expected response:
  - One write: address 0, data 28'hA123456.
  - oDone=1 and oCPUReset=0 one cycle after 7B is accepted.
- Back-to-back 3-word frame with iByteValid held high: expect three writes at addresses 0, 1, 2, each exactly one cycle after its 4th byte, with no oByteReady deassertion.
- Bad checksum: the same single-word frame with checksum 0x7C. Expected response:
  - One write occurs.
  - oError=1 and oCPUReset stays 1.
  - iStart then returns the loader to SYNC with oError=0.
- Garbage before sync and N==0: send 00 FF A5 00 00 00. Expected response:
  - The leading 00 and FF are discarded.
  - No writes occur.
  - The final 00 is the valid checksum, so oDone=1.
- Oversize count: A5 01 01 (N=257 > DEPTH=256) gives oError=1 immediately, with no writes. oByteReady=0 until iStart.
